perceptron_comm_controller_n: RTL and testbench
===============================================

# perceptron_comm_controller_n

Parametrised UART command controller for an N-input perceptron. It sits between the UART byte receiver/transmitter and the perceptron datapath. It decodes opcode-framed byte packets to load weight and input vectors of arbitrary width, and returns a headered read-back packet of weights and result. Unlike the fixed 2×16-bit controller, it acknowledges every command, rejects unknown opcodes, and aborts stalled transfers on an inter-byte timeout.

## Interface
Parameters:
- N_INPUTS, 2, number of weights/inputs
- DATA_WIDTH, 16, bits per weight/input/result; must be a multiple of 8
- TIMEOUT_CYCLES, 120000, maximum idle cycles while mid-packet (rx or tx) before abort
- OP_READ / OP_WRITE_WEIGHTS / OP_WRITE_INPUTS, 5 / 50 / 51, request opcodes
- OP_READ_RESPONSE / OP_WRITE_RESPONSE_OK / OP_WRITE_RESPONSE_ERR, 100 / 101 / 102, response bytes

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- rx_byte  in  8  received byte
- rx_ready  in  1  level, high while rx_byte is valid and unconsumed
- rx_clear  out  1  one-cycle pulse: byte consumed
- tx_busy  in  1  UART transmitter busy
- tx_byte  out  8  byte to transmit
- tx_send  out  1  one-cycle transmit strobe
- weights_in  in  N_INPUTS*DATA_WIDTH  current weights; element i at [i*DATA_WIDTH +: DATA_WIDTH]
- result_in  in  DATA_WIDTH  current perceptron result
- weights_out  out  N_INPUTS*DATA_WIDTH  new weights, same packing
- inputs_out  out  N_INPUTS*DATA_WIDTH  new inputs, same packing
- weight_write  out  1  one-cycle pulse: weights_out valid and committed
- input_write  out  1  one-cycle pulse: inputs_out valid and committed

## Operation
- Payload length P = N_INPUTS*DATA_WIDTH/8 bytes. Order: element 0 first; within an element, MSB byte first.
- States:
  - IDLE
  - RX_RELEASE (wait for rx_ready low)
  - RX_PAYLOAD
  - COMMIT
  - TX_LOAD
  - TX_WAIT_HI
  - TX_WAIT_LO
- IDLE, rx_ready=1: consume the opcode.
  - OP_WRITE_*: clear the byte counter and go to RX_PAYLOAD.
  - OP_READ: snapshot weights_in and result_in into the tx shadow, queue OP_READ_RESPONSE, P weight bytes, then DATA_WIDTH/8 result bytes.
  - Any other opcode: queue a single OP_WRITE_RESPONSE_ERR.
- Every consumed byte: rx_clear pulses, then the FSM passes through RX_RELEASE until rx_ready=0. A level-held byte is never consumed twice.
- RX_PAYLOAD: bytes shift into a staging register, not into the outputs. After byte P, go to COMMIT.
- COMMIT: copy staging to weights_out or inputs_out, pulse the matching write strobe, queue OP_WRITE_RESPONSE_OK.
- TX sequence, per byte:
  - TX_LOAD waits for tx_busy=0, then drives tx_byte and pulses tx_send.
  - TX_WAIT_HI waits for tx_busy=1.
  - TX_WAIT_LO waits for tx_busy=0.
  - Next byte or IDLE.
- Timeout: the counter resets on every consumed byte and every tx_busy edge. It counts in RX_PAYLOAD, RX_RELEASE, TX_WAIT_HI and TX_WAIT_LO.
  - Reaching TIMEOUT_CYCLES in an RX state: discard staging, queue OP_WRITE_RESPONSE_ERR.
  - Reaching TIMEOUT_CYCLES in a TX state: abort to IDLE with no response.
- rx_ready during TX states is ignored; the byte is left pending and handled from IDLE.

## Timing
- Reset values:
  - All outputs 0.
  - Staging register, shadow and counters 0; FSM in IDLE.
- Reset mid-operation: any packet in progress is dropped. No strobe or tx_send occurs after the reset edge.
- rx_clear is high in the cycle after the edge that samples rx_ready=1.
- weights_out/inputs_out change on the same edge that raises weight_write/input_write. Outputs are atomic: never partially updated.
- First tx_send comes no earlier than 1 cycle after COMMIT or opcode acceptance, and only with tx_busy=0.
- tx_byte is stable from the tx_send cycle until tx_busy falls.
- Strobes never overlap. At most one of weight_write, input_write, tx_send, rx_clear is high per cycle.
- Byte counter width is clog2(P+1). Timeout counter width is clog2(TIMEOUT_CYCLES+1). No wrap: the timeout counter saturates.

## Test plan
(N_INPUTS=2, DATA_WIDTH=16, TIMEOUT_CYCLES=64 unless stated)
- Write weights: send 50, 0x12, 0x34, 0x56, 0x78 -> weights_out=0x5678_1234, exactly one weight_write pulse, one tx byte 101; inputs_out unchanged.
- Write inputs: send 51, 70, 71, 72, 73 -> inputs_out=0x4849_4647, one input_write pulse, tx 101; weights_out unchanged.
- Read: weights_in={16'd102,16'd101}, result_in=103; send 5 -> tx 100, 0, 101, 0, 102, 0, 103. Each tx_send follows a tx_busy fall. Changing weights_in mid-packet does not alter the bytes.
- Unknown opcode 7 -> single tx 102, no write strobes; a following valid write works.
- Timeout: send 50, 0x12, 0x34, then silence for 64 cycles -> tx 102, weights_out unchanged. rx_ready held high for 10 cycles yields a single rx_clear.
- Reset: rst_n low for 1 cycle during the third read byte -> all outputs 0 on the next edge, no further tx_send, FSM in IDLE.

Source files
------------

// File: rtl/perceptron_comm_controller_n.sv
// rtl/perceptron_comm_controller_n.sv - UART command controller for an N-input perceptron
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   rx_byte, rx_ready       received byte and its level-held valid flag
//   rx_clear                one-cycle pulse: current rx byte consumed
//   tx_busy                 UART transmitter busy
//   tx_byte, tx_send        byte to transmit and its one-cycle strobe
//   weights_in, result_in   live perceptron state, snapshotted for read-back
//   weights_out, inputs_out committed vectors, element i at [i*DATA_WIDTH +: DATA_WIDTH]
//   weight_write, input_write one-cycle commit pulses
module perceptron_comm_controller_n #(
  parameter int N_INPUTS              = 2,
  parameter int DATA_WIDTH            = 16,
  parameter int TIMEOUT_CYCLES        = 120000,
  parameter int OP_READ               = 5,
  parameter int OP_WRITE_WEIGHTS      = 50,
  parameter int OP_WRITE_INPUTS       = 51,
  parameter int OP_READ_RESPONSE      = 100,
  parameter int OP_WRITE_RESPONSE_OK  = 101,
  parameter int OP_WRITE_RESPONSE_ERR = 102
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [7:0]                     rx_byte,
  input  logic                           rx_ready,
  output logic                           rx_clear,
  input  logic                           tx_busy,
  output logic [7:0]                     tx_byte,
  output logic                           tx_send,
  input  logic [N_INPUTS*DATA_WIDTH-1:0] weights_in,
  input  logic [DATA_WIDTH-1:0]          result_in,
  output logic [N_INPUTS*DATA_WIDTH-1:0] weights_out,
  output logic [N_INPUTS*DATA_WIDTH-1:0] inputs_out,
  output logic                           weight_write,
  output logic                           input_write
);
  localparam int VW  = N_INPUTS * DATA_WIDTH;
  localparam int P   = VW / 8;
  localparam int RB  = DATA_WIDTH / 8;
  localparam int SB  = 1 + P + RB;            // longest response: header + weights + result
  localparam int SW  = SB * 8;
  localparam int BCW = $clog2(P + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int XCW = $clog2(SB + 1);

  localparam logic [7:0]     OPR     = 8'(OP_READ);
  localparam logic [7:0]     OPW     = 8'(OP_WRITE_WEIGHTS);
  localparam logic [7:0]     OPI     = 8'(OP_WRITE_INPUTS);
  localparam logic [7:0]     RSP_RD  = 8'(OP_READ_RESPONSE);
  localparam logic [7:0]     RSP_OK  = 8'(OP_WRITE_RESPONSE_OK);
  localparam logic [7:0]     RSP_ERR = 8'(OP_WRITE_RESPONSE_ERR);
  localparam logic [BCW-1:0] P_B     = BCW'(P);
  localparam logic [TCW-1:0] TMO_MAX = TCW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_RX_RELEASE, S_RX_PAYLOAD, S_COMMIT, S_TX_LOAD, S_TX_WAIT_HI, S_TX_WAIT_LO
  } state_t;
  typedef enum logic [1:0] {K_NONE, K_WEIGHTS, K_INPUTS} kind_t;

  state_t          state, state_d;
  kind_t           kind;
  logic [BCW-1:0]  byte_cnt;
  logic [TCW-1:0]  tmo_cnt;
  logic [XCW-1:0]  tx_cnt;
  logic [VW-1:0]   staging;
  logic [SW-1:0]   shadow;
  logic            tx_busy_q;

  logic [VW-1:0]   rd_payload, commit_vec;
  logic            consume, commit, send, rx_abort, tx_abort, counting, tmo_hit;

  // Wire order puts element 0 first, MSB byte first; staging fills from the
  // bottom so the first received byte ends up at the top.
  always_comb begin
    rd_payload = '0;
    commit_vec = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      rd_payload[VW-(i+1)*DATA_WIDTH +: DATA_WIDTH] = weights_in[i*DATA_WIDTH +: DATA_WIDTH];
      commit_vec[i*DATA_WIDTH +: DATA_WIDTH]        = staging[VW-(i+1)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign counting = state inside {S_RX_RELEASE, S_RX_PAYLOAD, S_TX_WAIT_HI, S_TX_WAIT_LO};
  assign tmo_hit  = (tmo_cnt == TMO_MAX);

  always_comb begin
    state_d  = state;
    consume  = 1'b0;
    commit   = 1'b0;
    send     = 1'b0;
    rx_abort = 1'b0;
    tx_abort = 1'b0;
    case (state)
      S_IDLE: if (rx_ready) begin
        consume = 1'b1;
        state_d = S_RX_RELEASE;
      end
      S_RX_RELEASE: begin
        if (tmo_hit) begin
          rx_abort = 1'b1;
          state_d  = S_TX_LOAD;
        end else if (!rx_ready) begin
          if (kind == K_NONE)      state_d = S_TX_LOAD;
          else if (byte_cnt == P_B) state_d = S_COMMIT;
          else                      state_d = S_RX_PAYLOAD;
        end
      end
      S_RX_PAYLOAD: begin
        if (tmo_hit) begin
          rx_abort = 1'b1;
          state_d  = S_TX_LOAD;
        end else if (rx_ready) begin
          consume = 1'b1;
          state_d = S_RX_RELEASE;
        end
      end
      S_COMMIT: begin
        commit  = 1'b1;
        state_d = S_TX_LOAD;
      end
      S_TX_LOAD: if (!tx_busy) begin
        send    = 1'b1;
        state_d = S_TX_WAIT_HI;
      end
      S_TX_WAIT_HI: begin
        if (tmo_hit) begin
          tx_abort = 1'b1;
          state_d  = S_IDLE;
        end else if (tx_busy) begin
          state_d = S_TX_WAIT_LO;
        end
      end
      S_TX_WAIT_LO: begin
        if (tmo_hit) begin
          tx_abort = 1'b1;
          state_d  = S_IDLE;
        end else if (!tx_busy) begin
          state_d = (tx_cnt == '0) ? S_IDLE : S_TX_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      kind         <= K_NONE;
      byte_cnt     <= '0;
      tmo_cnt      <= '0;
      tx_cnt       <= '0;
      staging      <= '0;
      shadow       <= '0;
      tx_busy_q    <= 1'b0;
      rx_clear     <= 1'b0;
      tx_byte      <= '0;
      tx_send      <= 1'b0;
      weights_out  <= '0;
      inputs_out   <= '0;
      weight_write <= 1'b0;
      input_write  <= 1'b0;
    end else begin
      state        <= state_d;
      tx_busy_q    <= tx_busy;
      rx_clear     <= consume;
      tx_send      <= send;
      weight_write <= commit && (kind == K_WEIGHTS);
      input_write  <= commit && (kind == K_INPUTS);

      // Idle time is measured only while waiting mid-packet; leaving those
      // states, consuming a byte or any tx_busy transition restarts it.
      if (!counting || consume || (tx_busy != tx_busy_q)) tmo_cnt <= '0;
      else if (!tmo_hit)                                  tmo_cnt <= tmo_cnt + 1'b1;

      if (consume && state == S_IDLE) begin
        byte_cnt <= '0;
        if (rx_byte == OPW) begin
          kind <= K_WEIGHTS;
        end else if (rx_byte == OPI) begin
          kind <= K_INPUTS;
        end else begin
          kind <= K_NONE;
          if (rx_byte == OPR) begin
            shadow <= {RSP_RD, rd_payload, result_in};
            tx_cnt <= XCW'(SB);
          end else begin
            shadow <= {RSP_ERR, {(SW-8){1'b0}}};
            tx_cnt <= XCW'(1);
          end
        end
      end

      if (consume && state == S_RX_PAYLOAD) begin
        staging  <= (staging << 8) | VW'(rx_byte);
        byte_cnt <= byte_cnt + 1'b1;
      end

      if (commit) begin
        if (kind == K_WEIGHTS) weights_out <= commit_vec;
        else                   inputs_out  <= commit_vec;
        kind   <= K_NONE;
        shadow <= {RSP_OK, {(SW-8){1'b0}}};
        tx_cnt <= XCW'(1);
      end

      if (rx_abort) begin
        staging  <= '0;
        byte_cnt <= '0;
        kind     <= K_NONE;
        shadow   <= {RSP_ERR, {(SW-8){1'b0}}};
        tx_cnt   <= XCW'(1);
      end

      if (send) begin
        tx_byte <= shadow[SW-1 -: 8];
        shadow  <= shadow << 8;
        tx_cnt  <= tx_cnt - 1'b1;
      end

      if (tx_abort) begin
        tx_cnt <= '0;
        shadow <= '0;
      end
    end
  end
endmodule

// File: tb/tb_perceptron_comm_controller_n.sv
// tb/tb_perceptron_comm_controller_n.sv - self-checking bench for perceptron_comm_controller_n
module tb_perceptron_comm_controller_n;
  localparam int N   = 2;
  localparam int DW  = 16;
  localparam int TMO = 64;
  localparam int VW  = N * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    rx_byte;
  logic          rx_ready;
  logic          rx_clear;
  logic          tx_busy;
  logic [7:0]    tx_byte;
  logic          tx_send;
  logic [VW-1:0] weights_in;
  logic [DW-1:0] result_in;
  logic [VW-1:0] weights_out;
  logic [VW-1:0] inputs_out;
  logic          weight_write;
  logic          input_write;

  always #5 clk = ~clk;

  perceptron_comm_controller_n #(
    .N_INPUTS(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_ready(rx_ready), .rx_clear(rx_clear),
    .tx_busy(tx_busy), .tx_byte(tx_byte), .tx_send(tx_send), .weights_in(weights_in),
    .result_in(result_in), .weights_out(weights_out), .inputs_out(inputs_out),
    .weight_write(weight_write), .input_write(input_write)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Strobe monitors and UART transmitter model
  byte unsigned tx_q[$];
  int n_ww = 0, n_iw = 0, n_clr = 0, n_send = 0;
  int n_overlap = 0, n_send_busy = 0, n_unstable = 0, n_rst = 0;
  bit tx_hang = 1'b0;

  always @(negedge clk) begin
    if (weight_write) n_ww++;
    if (input_write)  n_iw++;
    if (rx_clear)     n_clr++;
    if (tx_send)      n_send++;
    if (int'(weight_write) + int'(input_write) + int'(tx_send) + int'(rx_clear) > 1) n_overlap++;
  end

  initial begin
    logic [7:0] held;
    int         gen;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_send && !tx_hang) begin
        held = tx_byte;
        gen  = n_rst;
        tx_q.push_back(tx_byte);
        tx_busy = 1'b1;
        repeat ($urandom_range(2, 6)) begin
          @(negedge clk);
          if (tx_send) n_send_busy++;
          if (gen == n_rst && tx_byte !== held) n_unstable++;
        end
        tx_busy = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int hold);
    int t;
    @(negedge clk);
    rx_byte  = b;
    rx_ready = 1'b1;
    t = 0;
    while (!rx_clear && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("rx_clear_seen", 64'(rx_clear), 64'd1);
    repeat (hold) @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic wait_tx(input int n);
    int t;
    t = 0;
    while (tx_q.size() < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (12) @(negedge clk);
    check("tx_count", 64'(tx_q.size()), 64'(n));
  endtask

  // Reference model: committed vectors and expected response stream
  logic [VW-1:0] m_w = '0, m_i = '0;

  function automatic logic [7:0] pl_byte(input logic [31:0] pl, input int j);
    return pl[(3 - j) * 8 +: 8];
  endfunction

  task automatic run_packet(input logic [7:0] op, input logic [31:0] pl);
    byte unsigned exp_q[$];
    int ww0, iw0, exp_ww, exp_iw;
    logic [VW-1:0] v;
    ww0 = n_ww; iw0 = n_iw; exp_ww = 0; exp_iw = 0;
    tx_q.delete();
    if (op == 8'd50 || op == 8'd51) begin
      v = '0;
      for (int k = 0; k < N; k++)
        v[k*DW +: DW] = DW'(pl_byte(pl, 2*k) * 256 + pl_byte(pl, 2*k + 1));
      if (op == 8'd50) begin m_w = v; exp_ww = 1; end
      else             begin m_i = v; exp_iw = 1; end
      exp_q.push_back(8'd101);
    end else if (op == 8'd5) begin
      exp_q.push_back(8'd100);
      for (int k = 0; k < N; k++) begin
        exp_q.push_back(8'(weights_in[k*DW +: DW] / 256));
        exp_q.push_back(8'(weights_in[k*DW +: DW] % 256));
      end
      exp_q.push_back(8'(result_in / 256));
      exp_q.push_back(8'(result_in % 256));
    end else begin
      exp_q.push_back(8'd102);
    end
    send_byte(op, 0);
    if (op == 8'd50 || op == 8'd51)
      for (int j = 0; j < 4; j++) send_byte(pl_byte(pl, j), 0);
    wait_tx(exp_q.size());
    for (int j = 0; j < exp_q.size() && j < tx_q.size(); j++)
      check($sformatf("tx_byte[%0d] op=%0d", j, op), 64'(tx_q[j]), 64'(exp_q[j]));
    check("weights_out", 64'(weights_out), 64'(m_w));
    check("inputs_out", 64'(inputs_out), 64'(m_i));
    check("weight_write_pulses", 64'(n_ww - ww0), 64'(exp_ww));
    check("input_write_pulses", 64'(n_iw - iw0), 64'(exp_iw));
  endtask

  typedef struct {
    logic [7:0]    op;
    logic [31:0]   pl;
    logic [VW-1:0] w_in;
    logic [DW-1:0] r_in;
    logic [7:0]    rsp0;
    int            rsp_len;
    logic [VW-1:0] exp_w;
    logic [VW-1:0] exp_i;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int c0, s0;
    logic [7:0] op;
    vecs[0] = '{8'd50, 32'h12345678, '0, '0, 8'd101, 1, 32'h56781234, 32'h0};
    vecs[1] = '{8'd51, 32'h46474849, '0, '0, 8'd101, 1, 32'h56781234, 32'h48494647};
    vecs[2] = '{8'd5,  32'h0, {16'd102, 16'd101}, 16'd103, 8'd100, 7, 32'h56781234, 32'h48494647};
    vecs[3] = '{8'd7,  32'h0, '0, '0, 8'd102, 1, 32'h56781234, 32'h48494647};
    vecs[4] = '{8'd50, 32'hA1B2C3D4, '0, '0, 8'd101, 1, 32'hC3D4A1B2, 32'h48494647};

    rst_n = 1'b0; rx_ready = 1'b0; rx_byte = '0; weights_in = '0; result_in = '0;
    repeat (3) @(negedge clk);
    check("rst_rx_clear", 64'(rx_clear), 64'd0);
    check("rst_tx_send", 64'(tx_send), 64'd0);
    check("rst_tx_byte", 64'(tx_byte), 64'd0);
    check("rst_weights_out", 64'(weights_out), 64'd0);
    check("rst_inputs_out", 64'(inputs_out), 64'd0);
    check("rst_strobes", 64'({weight_write, input_write}), 64'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      weights_in = vecs[i].w_in;
      result_in  = vecs[i].r_in;
      run_packet(vecs[i].op, vecs[i].pl);
      check($sformatf("vec%0d_rsp0", i), 64'(tx_q.size() > 0 ? tx_q[0] : 8'd0), 64'(vecs[i].rsp0));
      check($sformatf("vec%0d_rsp_len", i), 64'(tx_q.size()), 64'(vecs[i].rsp_len));
      check($sformatf("vec%0d_weights", i), 64'(weights_out), 64'(vecs[i].exp_w));
      check($sformatf("vec%0d_inputs", i), 64'(inputs_out), 64'(vecs[i].exp_i));
    end

    // Read snapshot: weights_in changes after the header goes out
    weights_in = {16'd102, 16'd101}; result_in = 16'd103;
    tx_q.delete();
    send_byte(8'd5, 0);
    while (tx_q.size() < 1) @(negedge clk);
    weights_in = 32'hDEADBEEF; result_in = 16'hFFFF;
    wait_tx(7);
    check("snapshot_w0_lo", 64'(tx_q.size() > 2 ? tx_q[2] : 8'd0), 64'd101);
    check("snapshot_w1_lo", 64'(tx_q.size() > 4 ? tx_q[4] : 8'd0), 64'd102);
    check("snapshot_res_lo", 64'(tx_q.size() > 6 ? tx_q[6] : 8'd0), 64'd103);

    // Inter-byte timeout discards the partial packet
    tx_q.delete(); c0 = n_ww;
    send_byte(8'd50, 0); send_byte(8'h12, 0); send_byte(8'h34, 0);
    wait_tx(1);
    check("timeout_rsp", 64'(tx_q.size() > 0 ? tx_q[0] : 8'd0), 64'd102);
    check("timeout_weights_kept", 64'(weights_out), 64'(m_w));
    check("timeout_no_strobe", 64'(n_ww - c0), 64'd0);
    run_packet(8'd51, 32'h01020304);

    // Level-held rx byte is consumed once
    tx_q.delete(); c0 = n_clr;
    send_byte(8'd7, 10);
    wait_tx(1);
    check("held_rx_single_clear", 64'(n_clr - c0), 64'd1);
    check("held_rx_rsp", 64'(tx_q.size() > 0 ? tx_q[0] : 8'd0), 64'd102);

    // Transmitter never acknowledges: controller must abort and recover
    tx_hang = 1'b1; s0 = n_send;
    send_byte(8'd9, 0);
    repeat (TMO + 40) @(negedge clk);
    check("tx_abort_single_send", 64'(n_send - s0), 64'd1);
    tx_hang = 1'b0;
    run_packet(8'd50, 32'h0BADF00D);

    // Randomized packets against the model
    for (int r = 0; r < 24; r++) begin
      case ($urandom_range(0, 3))
        0: op = 8'd5;
        1: op = 8'd50;
        2: op = 8'd51;
        default: begin
          op = 8'($urandom_range(0, 255));
          if (op == 8'd5 || op == 8'd50 || op == 8'd51) op = 8'd200;
        end
      endcase
      weights_in = VW'($urandom);
      result_in  = DW'($urandom);
      run_packet(op, $urandom);
    end

    // Reset during the third byte of a read response
    weights_in = {16'd102, 16'd101}; result_in = 16'd103;
    tx_q.delete();
    send_byte(8'd5, 0);
    while (tx_q.size() < 3) @(negedge clk);
    rst_n = 1'b0; n_rst++;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_tx_byte", 64'(tx_byte), 64'd0);
    check("midrst_tx_send", 64'(tx_send), 64'd0);
    check("midrst_weights_out", 64'(weights_out), 64'd0);
    check("midrst_inputs_out", 64'(inputs_out), 64'd0);
    check("midrst_strobes", 64'({weight_write, input_write, rx_clear}), 64'd0);
    m_w = '0; m_i = '0;
    s0 = n_send;
    repeat (200) @(negedge clk);
    check("midrst_no_more_send", 64'(n_send - s0), 64'd0);
    run_packet(8'd51, 32'h46474849);

    check("strobe_overlap", 64'(n_overlap), 64'd0);
    check("send_while_busy", 64'(n_send_busy), 64'd0);
    check("tx_byte_unstable", 64'(n_unstable), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit");
  end
endmodule
